// File: rtl/ball_motion.sv
// ball_motion: ball position/velocity keeper for the pong video pipeline.
// Tracks the raster from the sync generator strobes, decodes the ball pixel,
// latches paddle collisions during the frame and moves the ball once per
// frame on vreset. Between points the ball is hidden for SERVE_FRAMES frames.
//
// Ports:
//   clk           pixel clock (shared with the sync generators)
//   reset         asynchronous, active-low reset
//   hreset        1-cycle strobe at the start of each line
//   hblank        horizontal blanking
//   vreset        1-cycle strobe at the start of each frame (with an hreset)
//   vblank        vertical blanking
//   lpaddle_video left paddle pixel active
//   rpaddle_video right paddle pixel active
//   ball_video    ball pixel active (combinational)
//   miss_left     1-cycle pulse when the ball passes X_MIN
//   miss_right    1-cycle pulse when the ball passes X_MAX
//   serving       high while the ball is hidden between points
//   ball_x/ball_y ball left-edge x / top-edge y
module ball_motion #(
  parameter int BALL_SIZE    = 4,
  parameter int X_MIN        = 80,
  parameter int X_MAX        = 440,
  parameter int Y_MIN        = 16,
  parameter int Y_MAX        = 250,
  parameter int X_START      = 256,
  parameter int Y_START      = 128,
  parameter int H_SPEED      = 2,
  parameter int V_SPEED      = 1,
  parameter int SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hreset,
  input  logic       hblank,
  input  logic       vreset,
  input  logic       vblank,
  input  logic       lpaddle_video,
  input  logic       rpaddle_video,
  output logic       ball_video,
  output logic       miss_left,
  output logic       miss_right,
  output logic       serving,
  output logic [8:0] ball_x,
  output logic [8:0] ball_y
);

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);

  // 10-bit thresholds so the sums below never wrap
  localparam logic [9:0] SIZE10 = 10'(BALL_SIZE);
  localparam logic [9:0] X_LO   = 10'(X_MIN + H_SPEED);
  localparam logic [9:0] X_HI   = 10'(X_MAX + 1);
  localparam logic [9:0] Y_LO   = 10'(Y_MIN + V_SPEED);
  localparam logic [9:0] Y_HI   = 10'(Y_MAX + 1);
  localparam logic [9:0] HSP10  = 10'(H_SPEED);
  localparam logic [9:0] VSP10  = 10'(V_SPEED);

  typedef enum logic {SERVE, PLAY} state_t;

  state_t           state, state_nxt;
  logic [8:0]       hcount, vcount;
  logic [CNT_W-1:0] serve_cnt;
  logic             dir_right, dir_down;
  logic             lhit, rhit;

  logic [9:0] x10, y10, h10, v10;
  logic       in_box, dir_ref, miss_l, miss_r, serve_done;

  assign x10 = {1'b0, ball_x};
  assign y10 = {1'b0, ball_y};
  assign h10 = {1'b0, hcount};
  assign v10 = {1'b0, vcount};

  assign in_box = (h10 >= x10) && (h10 < x10 + SIZE10) &&
                  (v10 >= y10) && (v10 < y10 + SIZE10);

  // Direction after paddle reflection; a hit on the trailing side is ignored.
  always_comb begin
    dir_ref = dir_right;
    if (lhit && !dir_right)     dir_ref = 1'b1;
    else if (rhit && dir_right) dir_ref = 1'b0;
  end

  assign miss_l     = (state == PLAY) && !dir_ref && (x10 < X_LO);
  assign miss_r     = (state == PLAY) && dir_ref && (x10 + SIZE10 + HSP10 > X_HI);
  assign serve_done = (serve_cnt == CNT_W'(SERVE_FRAMES - 1));

  // Raster counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (vreset) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hreset) begin
      hcount <= '0;
      vcount <= vcount + 9'd1;
    end else if (hcount != 9'd511) begin
      hcount <= hcount + 9'd1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SERVE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (vreset) begin
      case (state)
        SERVE:   if (serve_done) state_nxt = PLAY;
        PLAY:    if (miss_l || miss_r) state_nxt = SERVE;
        default: state_nxt = SERVE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    serving    = (state == SERVE);
    ball_video = (state == PLAY) && !hblank && !vblank && in_box;
  end

  // Motion, hit latches and miss pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      serve_cnt  <= '0;
      ball_x     <= 9'(X_START);
      ball_y     <= 9'(Y_START);
      dir_right  <= 1'b1;
      dir_down   <= 1'b1;
      lhit       <= 1'b0;
      rhit       <= 1'b0;
      miss_left  <= 1'b0;
      miss_right <= 1'b0;
    end else begin
      miss_left  <= vreset && miss_l;
      miss_right <= vreset && miss_r;
      if (vreset) begin
        // frame boundary: clear beats a same-cycle hit
        lhit <= 1'b0;
        rhit <= 1'b0;
        if (state == SERVE) begin
          serve_cnt <= serve_done ? '0 : serve_cnt + 1'b1;
        end else begin
          dir_right <= dir_ref;
          if (miss_l || miss_r) begin
            // reload and serve toward the side that missed; no vertical step
            ball_x    <= 9'(X_START);
            ball_y    <= 9'(Y_START);
            dir_right <= miss_r;
          end else begin
            ball_x <= dir_ref ? ball_x + 9'(H_SPEED) : ball_x - 9'(H_SPEED);
            if (dir_down) begin
              if (y10 + SIZE10 + VSP10 > Y_HI) dir_down <= 1'b0;
              else                             ball_y   <= ball_y + 9'(V_SPEED);
            end else begin
              if (y10 < Y_LO) dir_down <= 1'b1;
              else            ball_y   <= ball_y - 9'(V_SPEED);
            end
          end
        end
      end else if (ball_video) begin
        if (lpaddle_video) lhit <= 1'b1;
        if (rpaddle_video) rhit <= 1'b1;
      end
    end
  end

endmodule
